// File: rtl/riscv_pkg.sv
// Shared integer-core constants: data width, register address width and the zero register.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_pending_scoreboard.sv
// Per-register in-flight load counters and the decode stall they imply.
// A source is not a hazard when its last outstanding load is being bypassed from WB this cycle.
module reg_pending_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_reg_write_en_w,
  input  logic [REG_ADDR_W-1:0] i_rd_w,
  input  logic                  i_load_retire_w,
  input  logic [REG_ADDR_W-1:0] i_rs1_d,
  input  logic [REG_ADDR_W-1:0] i_rs2_d,
  input  logic                  i_rs1_used_d,
  input  logic                  i_rs2_used_d,
  input  logic                  i_issue_load_d,
  input  logic [REG_ADDR_W-1:0] i_issue_rd_d,
  input  logic                  i_kill_load_e,
  input  logic [REG_ADDR_W-1:0] i_kill_rd_e,
  output logic                  o_stall_d
);

  logic [NREGS-1:0][1:0] w_pend;
  logic [NREGS-1:0]      w_over;
  logic [NREGS-1:0]      w_under;

  assign w_pend[0]  = 2'd0;
  assign w_over[0]  = 1'b0;
  assign w_under[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    logic              w_inc;
    logic              w_dec_w;
    logic              w_dec_k;
    logic signed [3:0] w_sum;
    logic [1:0]        r_cnt;

    assign w_inc   = i_issue_load_d && (i_issue_rd_d == REG_ADDR_W'(r));
    assign w_dec_w = i_load_retire_w && i_reg_write_en_w && (i_rd_w == REG_ADDR_W'(r));
    assign w_dec_k = i_kill_load_e && (i_kill_rd_e == REG_ADDR_W'(r));
    // Net of all same-cycle events; range is -2..+4 so 4 signed bits suffice.
    assign w_sum   = 4'(r_cnt) + 4'(w_inc) - 4'(w_dec_w) - 4'(w_dec_k);

    assign w_over[r]  = (w_sum > 4'sd3);
    assign w_under[r] = (w_sum < 4'sd0);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)             r_cnt <= 2'd0;
      else if (w_over[r])   r_cnt <= 2'd3;
      else if (w_under[r])  r_cnt <= 2'd0;
      else                  r_cnt <= w_sum[1:0];
    end

    assign w_pend[r] = r_cnt;
  end

  // Saturation only hides a pipeline-control bug, so flag it loudly.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (w_over == '0);
      assert (w_under == '0);
    end
  end

  logic w_cov1, w_cov2, w_haz1, w_haz2;

  assign w_cov1 = BYPASS && (w_pend[i_rs1_d] == 2'd1) && i_load_retire_w &&
                  i_reg_write_en_w && (i_rd_w == i_rs1_d);
  assign w_cov2 = BYPASS && (w_pend[i_rs2_d] == 2'd1) && i_load_retire_w &&
                  i_reg_write_en_w && (i_rd_w == i_rs2_d);

  assign w_haz1 = i_rs1_used_d && (i_rs1_d != ZERO_REG) && (w_pend[i_rs1_d] != 2'd0) && !w_cov1;
  assign w_haz2 = i_rs2_used_d && (i_rs2_d != ZERO_REG) && (w_pend[i_rs2_d] != 2'd0) && !w_cov2;

  assign o_stall_d = w_haz1 || w_haz2;

endmodule

// File: rtl/register_file_bypass.sv
// Integer register file with WB write-through bypass to the two decode read ports,
// x0 hardwired to zero, and a load-pending scoreboard driving StallD.
module register_file_bypass
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteEnW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [XLEN-1:0]       ResultW,
  input  logic                  LoadRetireW,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic                  Rs1UsedD,
  input  logic                  Rs2UsedD,
  input  logic                  IssueLoadD,
  input  logic [REG_ADDR_W-1:0] IssueRdD,
  input  logic                  KillLoadE,
  input  logic [REG_ADDR_W-1:0] KillRdE,
  output logic [XLEN-1:0]       RD1D,
  output logic [XLEN-1:0]       RD2D,
  output logic                  StallD
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_en;
  logic            w_byp1;
  logic            w_byp2;

  assign w_wr_en = RegWriteEnW && (RdW != ZERO_REG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[RdW] <= ResultW;
    end
  end

  assign w_byp1 = BYPASS && w_wr_en && (RdW == Rs1D);
  assign w_byp2 = BYPASS && w_wr_en && (RdW == Rs2D);

  assign RD1D = (Rs1D == ZERO_REG) ? '0 : (w_byp1 ? ResultW : r_regs[Rs1D]);
  assign RD2D = (Rs2D == ZERO_REG) ? '0 : (w_byp2 ? ResultW : r_regs[Rs2D]);

  reg_pending_scoreboard #(
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk              (clk),
    .rst              (rst),
    .i_reg_write_en_w (RegWriteEnW),
    .i_rd_w           (RdW),
    .i_load_retire_w  (LoadRetireW),
    .i_rs1_d          (Rs1D),
    .i_rs2_d          (Rs2D),
    .i_rs1_used_d     (Rs1UsedD),
    .i_rs2_used_d     (Rs2UsedD),
    .i_issue_load_d   (IssueLoadD),
    .i_issue_rd_d     (IssueRdD),
    .i_kill_load_e    (KillLoadE),
    .i_kill_rd_e      (KillRdE),
    .o_stall_d        (StallD)
  );

endmodule
